// File: rtl/buffer_pkg.sv
// buffer_pkg -- shared constants and types for the serial pattern buffer.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and word count
//   word_t                        : one stored word at the default width
//   BUFFER_PATTERN                : read-only pattern, element [i] is word i
// Optional build macro: BUFFER_PARITY_EN (see buffer_serializer).
package buffer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // Packed so it can seed the top-level PATTERN parameter directly;
    // word0 sits in the least significant slot.
    localparam word_t [DEFAULT_DEPTH-1:0] BUFFER_PATTERN = {
        8'h0F,   // word3
        8'hF0,   // word2
        8'h3C,   // word1
        8'hA5    // word0
    };

endpackage

// File: rtl/buffer_serializer.sv
// buffer_serializer -- shifts one word out MSB first on a registered output.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   i_word       : word currently being sent (held stable by the parent)
//   o_d          : registered serial output
//   o_frame_end  : high while the last slot of the frame is being sent;
//                  the parent advances to the next word on that edge
// Macro BUFFER_PARITY_EN: adds a trailing odd-parity slot to every frame.
module buffer_serializer
    import buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_word,
    output logic             o_d,
    output logic             o_frame_end
);

`ifdef BUFFER_PARITY_EN
    localparam int SLOTS = WIDTH + 1;
`else
    localparam int SLOTS = WIDTH;
`endif
    localparam int            BW   = $clog2(SLOTS);
    localparam logic [BW-1:0] LAST = BW'(SLOTS - 1);

    logic [BW-1:0]    r_bit;
    logic             r_d;
    logic [WIDTH-1:0] w_shifted;
    logic             w_next_d;

    // Shifting left by the slot index puts the selected bit in the MSB,
    // which avoids a variable part-select with a mismatched index width.
    assign w_shifted   = i_word << r_bit;
    assign o_frame_end = (r_bit == LAST);
    assign o_d         = r_d;

    always_comb begin
        w_next_d = w_shifted[WIDTH-1];
`ifdef BUFFER_PARITY_EN
        // Odd parity: total ones across data plus this slot is odd.
        if (r_bit == LAST) w_next_d = ~^i_word;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d   <= 1'b0;
            r_bit <= '0;
        end else begin
            r_d   <= w_next_d;
            r_bit <= o_frame_end ? '0 : r_bit + BW'(1);
        end
    end

endmodule

// File: rtl/buffer.sv
// buffer -- free-running serial pattern generator. Holds DEPTH read-only
// words of WIDTH bits and streams them MSB first, word0..wordDEPTH-1,
// wrapping with no gap.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset (d=0, stream restarts at word0)
//   d     : registered serial output
// Parameters: WIDTH (>=2), DEPTH (power of two, >=2), PATTERN (packed
// words, word0 in the low slot; defaults to buffer_pkg::BUFFER_PATTERN).
// Macro BUFFER_PARITY_EN: appends an odd-parity slot to each frame.
module buffer
    import buffer_pkg::*;
#(
    parameter int                     WIDTH   = DEFAULT_WIDTH,
    parameter int                     DEPTH   = DEFAULT_DEPTH,
    parameter logic [DEPTH*WIDTH-1:0] PATTERN = BUFFER_PATTERN
) (
    input  logic clk,
    input  logic reset,
    output logic d
);

    localparam int WW = $clog2(DEPTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("buffer: WIDTH must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("buffer: DEPTH must be a power of two, at least 2");
    end

    logic [WIDTH-1:0] w_mem [DEPTH];
    logic [WW-1:0]    r_word_idx;
    logic             w_frame_end;

    // Constant storage unpacked so the word index selects with its exact width.
    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        assign w_mem[i] = PATTERN[i*WIDTH +: WIDTH];
    end

    // DEPTH is a power of two, so the index wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)            r_word_idx <= '0;
        else if (w_frame_end) r_word_idx <= r_word_idx + WW'(1);
    end

    buffer_serializer #(
        .WIDTH (WIDTH)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_word      (w_mem[r_word_idx]),
        .o_d         (d),
        .o_frame_end (w_frame_end)
    );

endmodule

// File: tb/tb_buffer.sv
// tb_buffer -- directed checks of the serial pattern buffer: reset output,
// first-frame latency, full-period stream and wrap, mid-frame reset
// restart, a reduced WIDTH=4/DEPTH=2 configuration and X-freedom.
module tb_buffer;

    logic clk;
    logic reset;
    logic d_main;
    logic d_small;

    int n_vec = 0;
    int n_err = 0;

    // Hand-written expected streams, first transmitted bit in the MSB.
`ifdef BUFFER_PARITY_EN
    localparam int MAIN_LEN  = 36;
    localparam int SMALL_LEN = 10;
    logic [35:0] main_s  = {8'hA5, 1'b1, 8'h3C, 1'b1, 8'hF0, 1'b1, 8'h0F, 1'b1};
    logic [9:0]  small_s = 10'b10011_01101;
`else
    localparam int MAIN_LEN  = 32;
    localparam int SMALL_LEN = 8;
    logic [35:0] main_s  = {4'h0, 32'hA53C_F00F};
    logic [9:0]  small_s = {2'b00, 8'b1001_0110};
`endif
    logic [7:0] a5 = 8'hA5;

    buffer u_main (
        .clk   (clk),
        .reset (reset),
        .d     (d_main)
    );

    buffer #(
        .WIDTH   (4),
        .DEPTH   (2),
        .PATTERN (8'h69)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .d     (d_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;

        // Reset held for two edges: output stays low.
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rst_main_%0d", i), d_main, 1'b0);
            check($sformatf("rst_small_%0d", i), d_small, 1'b0);
        end

        // Free run 40 edges: first frame A5, then 3C F0 0F and the wrap.
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("run_bit%0d", k), d_main,
                  main_s[MAIN_LEN-1 - (k % MAIN_LEN)]);
        end

        // Mid-frame reset at bit 3 of word1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < MAIN_LEN/4 + 3; k++) begin
            tick();
            check($sformatf("pre_bit%0d", k), d_main, main_s[MAIN_LEN-1 - k]);
        end
        reset = 1'b1;
        tick();
        check("midrst_d", d_main, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("restart_bit%0d", k), d_main, a5[7-k]);
        end

        // Reduced configuration: 1001_0110 repeating.
        reset = 1'b1;
        tick();
        check("small_rst", d_small, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 2*SMALL_LEN; k++) begin
            tick();
            check($sformatf("small_bit%0d", k), d_small,
                  small_s[SMALL_LEN-1 - (k % SMALL_LEN)]);
        end

        // Ten further free-running edges: never X/Z.
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("nox_%0d", k), $isunknown(d_main) | $isunknown(d_small), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
